// File: rtl/exp_horner_seq.sv
// Sequential degree-5 Horner evaluator for e^x (Q2.14 in, Q7.25 out) sharing one multiply-add.
// Define EXP_HORNER_SEQ_ROUND_EN to round-half-up each product instead of truncating.
module exp_horner_seq #(
   parameter int                   WIDTHIN  = 16,
   parameter int                   WIDTHOUT = 32,
   parameter logic [WIDTHIN-1:0]   A0       = 16'h4000,
   parameter logic [WIDTHIN-1:0]   A1       = 16'h4000,
   parameter logic [WIDTHIN-1:0]   A2       = 16'h2000,
   parameter logic [WIDTHIN-1:0]   A3       = 16'h0AAA,
   parameter logic [WIDTHIN-1:0]   A4       = 16'h02AA,
   parameter logic [WIDTHIN-1:0]   A5       = 16'h0088
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [WIDTHIN-1:0]      i_x,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [WIDTHOUT-1:0]     o_y
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state;
   logic [WIDTHIN-1:0]     x_reg;
   logic [WIDTHOUT-1:0]    acc;
   logic [2:0]             step;
   logic [WIDTHIN-1:0]     coef;
   logic [47:0]            product;
   logic [WIDTHOUT-1:0]    prod_trunc;
   logic [WIDTHOUT-1:0]    mac_sum;

   function automatic logic [WIDTHOUT-1:0] align(input logic [WIDTHIN-1:0] c);
      return {5'b0, c, 11'b0};
   endfunction

   // Coefficients are consumed from highest order downwards; A5 seeds the accumulator.
   always_comb begin
      coef = A0;
      case (step)
         3'd0:    coef = A4;
         3'd1:    coef = A3;
         3'd2:    coef = A2;
         3'd3:    coef = A1;
         default: coef = A0;
      endcase
   end

   assign product    = {16'b0, acc} * {32'b0, x_reg};
   assign prod_trunc = 32'(product >> 14);

`ifdef EXP_HORNER_SEQ_ROUND_EN
   assign mac_sum = prod_trunc + {31'b0, product[13]} + align(coef);
`else
   assign mac_sum = prod_trunc + align(coef);
`endif

   // Ready is combinational so a drain and a new acceptance can share one edge in DONE.
   assign o_ready = (state == IDLE) || ((state == DONE) && i_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         x_reg   <= '0;
         acc     <= '0;
         step    <= '0;
         o_y     <= '0;
         o_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  x_reg <= i_x;
                  acc   <= align(A5);
                  step  <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc  <= mac_sum;
               step <= step + 3'd1;
               if (step == 3'd4) begin
                  o_y     <= mac_sum;
                  o_valid <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  if (i_valid) begin
                     x_reg <= i_x;
                     acc   <= align(A5);
                     step  <= '0;
                     state <= CALC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/exp_horner_seq.md
Name: exp_horner_seq

Overview:
- Area-reduced e^x evaluator that time-shares one 32x16 multiplier and one 32-bit adder across all five Horner steps of the degree-5 Taylor polynomial.
- An FSM sequences the shared multiply-add and steps a coefficient selector.
- Uses the same valid/ready stream interface and Q2.14-in / Q7.25-out formats as the fully unrolled evaluator, so it drops in wherever throughput of one result per 6 cycles is acceptable.

Parameters:
- WIDTHIN, 16, input width (Q2.14)
- WIDTHOUT, 32, output/accumulator width (Q7.25)
- A0, 16'h4000, Taylor coefficient 1 (Q2.14)
- A1, 16'h4000, coefficient 1
- A2, 16'h2000, coefficient 1/2
- A3, 16'h0AAA, coefficient 1/6
- A4, 16'h02AA, coefficient 1/24
- A5, 16'h0088, coefficient 1/120

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream i_x valid
- o_ready  out  1  block can accept i_x this cycle
- i_x  in  WIDTHIN  operand x, Q2.14 unsigned
- o_valid  out  1  o_y holds a completed result
- i_ready  in  1  downstream accepts o_y this cycle
- o_y  out  WIDTHOUT  e^x approximation, Q7.25, low 32 bits kept

Behaviour:
- Reset values: state=IDLE, o_valid=0, o_ready=1, o_y=0, x register=0, accumulator=0, step=0.
- align(c) = {5'b0, c, 11'b0}, i.e. Q2.14 to Q7.25.
- mac(acc,x,c) = (acc*x)[45:14] + align(c); the 48-bit product is truncated and the sum wraps mod 2^32.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid: latch x, set acc=align(A5) and step=0, go to CALC.
- CALC:
  - o_ready=0; i_valid is ignored and no input is lost upstream because o_ready is low.
  - Each cycle: acc <= mac(acc, x, C[step]), with C[0..4] = A4, A3, A2, A1, A0; step increments.
  - On the step=4 update, also load o_y with the mac result and go to DONE.
- DONE:
  - o_valid=1; o_y is stable.
  - o_ready = i_ready.
  - i_ready=1 and i_valid=0: go to IDLE, o_valid falls.
  - i_ready=1 and i_valid=1: drain and accept a new x on the same edge, go to CALC (back-to-back).
  - i_ready=0: hold state, o_y, and o_valid indefinitely.
- Latency: the acceptance edge is E0; o_valid rises after E5. Peak throughput is one result per 6 cycles with back-to-back operation.
- o_y changes only on the E5 load; it is never modified in IDLE or CALC.
- Reset mid-CALC or mid-DONE: the result in flight is discarded, all registers return to reset values, and no o_valid pulse follows.
- x=0 collapses every product to 0, so the result equals align(A0).
- Overflow for large x silently wraps; no saturation.

Optional Feature:
- Macro: EXP_HORNER_SEQ_ROUND_EN
- Defined: mac adds product bit 13 to product[45:14] before the coefficient add (round-half-up), applied at all five steps.
- Undefined: plain truncation as above.
- Either way the latency, handshake, and FSM are identical.

Test Plan:
- x=16'h0000, i_ready=1 → o_valid rises 5 cycles after acceptance with o_y=32'h0200_0000; o_ready low in the 5 intervening cycles.
- x=16'h4000 (1.0) → o_y=32'h056E_E000, identical with and without EXP_HORNER_SEQ_ROUND_EN.
- Backpressure: i_ready=0 from completion for 10 cycles → o_valid=1, o_ready=0, o_y constant. Raise i_ready → o_valid drops the next cycle and o_ready=1.
- Back-to-back: in DONE, hold i_valid=1 and i_ready=1 with x2=16'h0000 → first result drained, x2 accepted on the same edge, next o_valid 5 cycles later with o_y=32'h0200_0000.
- Reset asserted during the third CALC cycle → o_valid=0, o_y=0, o_ready=1 immediately (asynchronously); a later fresh x=16'h4000 yields the correct 32'h056E_E000.
- Random x stream with random i_valid/i_ready gaps (1000 items) → every o_y matches the bit-accurate model, in order, with none dropped or duplicated.
